// File: rtl/axis_rx_pkg.sv
// Shared types and helpers for the AXI-Stream bank writer: FSM encoding and
// bank-index width derivation.
package axis_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECV   = 2'b01,
    ST_FINISH = 2'b11
  } rx_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A single bank needs no index bits at all.
  function automatic int bank_bits(input int num_banks);
    return (num_banks <= 1) ? 0 : clog2(num_banks);
  endfunction

endpackage

// File: rtl/axis_rx_bank_decode.sv
// One-hot bank strobe from the low bits of the beat counter, qualified by the
// stream handshake.
module axis_rx_bank_decode
  import axis_rx_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int SEL_W     = 2
) (
  input  logic                 accept,
  input  logic [SEL_W-1:0]     bank_idx,
  output logic [NUM_BANKS-1:0] bank_en
);

  generate
    if (NUM_BANKS == 1) begin : g_single
      logic unused_idx;
      assign unused_idx = ^bank_idx;
      assign bank_en    = accept;
    end else begin : g_multi
      always_comb begin
        bank_en = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
          bank_en[i] = accept && (bank_idx == SEL_W'(i));
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axis_rx_bank_writer.sv
// AXI-Stream receiver that spreads beats round-robin over NUM_BANKS buffer banks.
// Length checking and recv_err are built only when AXIS_RX_LEN_CHECK_EN is defined.
module axis_rx_bank_writer
  import axis_rx_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_BIT  = 16,
  parameter int NUM_BANKS = 4,
  parameter int CNT_W     = ADDR_BIT + bank_bits(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 recv_enable,
  input  logic [ADDR_BIT-1:0]  recv_base_addr,
  input  logic [CNT_W-1:0]     recv_len,
  output logic                 recv_busy,
  output logic                 recv_done,
  output logic                 recv_err,
  output logic                 s_axis_tready,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic [ADDR_BIT-1:0]  write_addr,
  output logic [DATA_W-1:0]    write_data,
  output logic [NUM_BANKS-1:0] write_bank_en,
  output logic                 write_enable
);

  localparam int BANK_BITS = bank_bits(NUM_BANKS);
  localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;

  // Handshake: a beat transfers on a rising edge where tvalid and tready are
  // both high; tready depends only on registered state, never on tvalid.
  rx_state_e           state_q, state_d;
  logic [ADDR_BIT-1:0] base_q, base_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    beat_cnt_next;
  logic                accept;
  logic                finish_beat;

`ifdef AXIS_RX_LEN_CHECK_EN
  logic [CNT_W-1:0]    len_q, len_d;
  logic                err_q, err_d;
  logic                len_hit;
  logic                len_mismatch;
`else
  logic                unused_len;
`endif

  assign s_axis_tready = (state_q == ST_RECV);
  assign accept        = s_axis_tready && s_axis_tvalid;
  assign beat_cnt_next = beat_cnt_q + CNT_W'(1);
  assign recv_busy     = (state_q == ST_RECV) || (state_q == ST_FINISH);
  assign recv_done     = (state_q == ST_FINISH);

`ifdef AXIS_RX_LEN_CHECK_EN
  // Beat numbers are 1-based here: beat_cnt_next is the number of the beat
  // being accepted now.
  assign len_hit      = (len_q != '0) && (beat_cnt_next == len_q);
  assign len_mismatch = (len_q != '0) && (s_axis_tlast != len_hit);
  assign finish_beat  = s_axis_tlast || len_hit;
  assign recv_err     = err_q;
`else
  assign unused_len   = ^recv_len;
  assign finish_beat  = s_axis_tlast;
  assign recv_err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    beat_cnt_d = beat_cnt_q;
`ifdef AXIS_RX_LEN_CHECK_EN
    len_d      = len_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (recv_enable) begin
          state_d    = ST_RECV;
          base_d     = recv_base_addr;
          beat_cnt_d = '0;
`ifdef AXIS_RX_LEN_CHECK_EN
          len_d      = recv_len;
          err_d      = 1'b0;
`endif
        end
      end
      ST_RECV: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_next;
          if (finish_beat) begin
            state_d = ST_FINISH;
`ifdef AXIS_RX_LEN_CHECK_EN
            err_d   = len_mismatch;
`endif
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      beat_cnt_q <= '0;
`ifdef AXIS_RX_LEN_CHECK_EN
      len_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef AXIS_RX_LEN_CHECK_EN
      len_q      <= len_d;
      err_q      <= err_d;
`endif
    end
  end

  // Low counter bits pick the bank, the rest is the in-bank offset.
  assign write_addr   = base_q + ADDR_BIT'(beat_cnt_q >> BANK_BITS);
  assign write_data   = s_axis_tdata;
  assign write_enable = |write_bank_en;

  axis_rx_bank_decode #(
    .NUM_BANKS (NUM_BANKS),
    .SEL_W     (SEL_W)
  ) u_bank_decode (
    .accept   (accept),
    .bank_idx (beat_cnt_q[SEL_W-1:0]),
    .bank_en  (write_bank_en)
  );

endmodule
